// File: rtl/lpif_quarter_beat_packer.sv
// Packs 2 or 4 LPIF beats into one quarter-rate group for the x16 asym2 TX mapper.
// Partial groups can be closed early with in_flush; unused slices are zero-padded.
`timescale 1ns/1ps

module lpif_quarter_beat_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_wr,
    input  logic             rst_wr,
    input  logic             m_gen2_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_state,
    input  logic [1:0]       in_protid,
    input  logic [255:0]     in_data,
    input  logic             in_dvalid,
    input  logic [15:0]      in_crc,
    input  logic             in_crc_valid,
    input  logic             in_flush,
    output logic [15:0]      dstrm_state,
    output logic [7:0]       dstrm_protid,
    output logic [1023:0]    dstrm_data,
    output logic [3:0]       dstrm_dvalid,
    output logic [63:0]      dstrm_crc,
    output logic [3:0]       dstrm_crc_valid,
    output logic [3:0]       dstrm_valid,
    output logic             grp_out_valid,
    input  logic             grp_out_ready,
    output logic [CNT_W-1:0] grp_cnt,
    output logic [CNT_W-1:0] pad_cnt
);

    logic [1:0]    idx;
    logic          gen2_q;

    logic [15:0]   acc_state;
    logic [7:0]    acc_protid;
    logic [1023:0] acc_data;
    logic [3:0]    acc_dvalid;
    logic [63:0]   acc_crc;
    logic [3:0]    acc_crc_valid;

    logic          cur_gen2;
    logic [1:0]    last_idx;
    logic          closing;
    logic          accept;
    logic          load;
    logic          handoff;

    logic [15:0]   nxt_state;
    logic [7:0]    nxt_protid;
    logic [1023:0] nxt_data;
    logic [3:0]    nxt_dvalid;
    logic [63:0]   nxt_crc;
    logic [3:0]    nxt_crc_valid;
    logic [3:0]    nxt_valid;

    // Group size is taken live at a group boundary and from the latched copy mid-group.
    assign cur_gen2 = (idx == 2'd0) ? m_gen2_mode : gen2_q;
    assign last_idx = cur_gen2 ? 2'd1 : 2'd3;
    assign closing  = in_flush || (idx == last_idx);
    assign in_ready = !closing || !grp_out_valid || grp_out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && closing;
    assign handoff  = grp_out_valid && grp_out_ready;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves a latch.
        nxt_state     = '0;
        nxt_protid    = '0;
        nxt_data      = '0;
        nxt_dvalid    = '0;
        nxt_crc       = '0;
        nxt_crc_valid = '0;
        nxt_valid     = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(idx)) begin
                nxt_state[4*k +: 4]    = acc_state[4*k +: 4];
                nxt_protid[2*k +: 2]   = acc_protid[2*k +: 2];
                nxt_data[256*k +: 256] = acc_data[256*k +: 256];
                nxt_dvalid[k]          = acc_dvalid[k];
                nxt_crc[16*k +: 16]    = acc_crc[16*k +: 16];
                nxt_crc_valid[k]       = acc_crc_valid[k];
                nxt_valid[k]           = 1'b1;
            end else if (k == int'(idx)) begin
                nxt_state[4*k +: 4]    = in_state;
                nxt_protid[2*k +: 2]   = in_protid;
                nxt_data[256*k +: 256] = in_data;
                nxt_dvalid[k]          = in_dvalid;
                nxt_crc[16*k +: 16]    = in_crc;
                nxt_crc_valid[k]       = in_crc_valid;
                nxt_valid[k]           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            // NOTE: the accumulator is cleared on reset so a discarded partial group cannot leak into the next one.
            idx             <= '0;
            gen2_q          <= 1'b0;
            acc_state       <= '0;
            acc_protid      <= '0;
            acc_data        <= '0;
            acc_dvalid      <= '0;
            acc_crc         <= '0;
            acc_crc_valid   <= '0;
            dstrm_state     <= '0;
            dstrm_protid    <= '0;
            dstrm_data      <= '0;
            dstrm_dvalid    <= '0;
            dstrm_crc       <= '0;
            dstrm_crc_valid <= '0;
            dstrm_valid     <= '0;
            grp_out_valid   <= 1'b0;
            grp_cnt         <= '0;
            pad_cnt         <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            if (accept && !closing) begin
                acc_state[4*idx +: 4]    <= in_state;
                acc_protid[2*idx +: 2]   <= in_protid;
                acc_data[256*idx +: 256] <= in_data;
                acc_dvalid[idx]          <= in_dvalid;
                acc_crc[16*idx +: 16]    <= in_crc;
                acc_crc_valid[idx]       <= in_crc_valid;
                idx                      <= idx + 2'd1;
                if (idx == 2'd0) begin
                    gen2_q <= m_gen2_mode;
                end
            end

            if (load) begin
                acc_state       <= '0;
                acc_protid      <= '0;
                acc_data        <= '0;
                acc_dvalid      <= '0;
                acc_crc         <= '0;
                acc_crc_valid   <= '0;
                idx             <= '0;
                dstrm_state     <= nxt_state;
                dstrm_protid    <= nxt_protid;
                dstrm_data      <= nxt_data;
                dstrm_dvalid    <= nxt_dvalid;
                dstrm_crc       <= nxt_crc;
                dstrm_crc_valid <= nxt_crc_valid;
                dstrm_valid     <= nxt_valid;
                grp_out_valid   <= 1'b1;
                if (in_flush && (idx != last_idx)) begin
                    pad_cnt <= pad_cnt + CNT_W'(1);
                end
            end else if (handoff) begin
                grp_out_valid <= 1'b0;
            end

            if (handoff) begin
                grp_cnt <= grp_cnt + CNT_W'(1);
            end
        end
    end

endmodule
